// File: rtl/seven_seg_count_decoder.sv
// -----------------------------------------------------------------------------
// seven_seg_count_decoder
//
// Reads the generation counter back from its three seven-segment digit codes
// and produces a binary count (0..999). The digit codes are latched on a
// sample request, then decoded and accumulated hundreds -> tens -> ones over
// three cycles. The result is compared against a programmable limit so game
// control can stop at a target generation.
//
// Ports:
//   clk           in   1   system clock, all state updates on posedge
//   reset         in   1   asynchronous active-low reset
//   sample        in   1   one-cycle conversion request, ignored while busy
//   hexThreeCode  in   7   ones-digit segment code (active-low, bit6=g..bit0=a)
//   hexFourCode   in   7   tens-digit segment code
//   hexFiveCode   in   7   hundreds-digit segment code
//   limit         in  10   target generation, 0 disables the compare
//   count         out 10   last converted value, held between conversions
//   countValid    out  1   one-cycle pulse when count and flags update
//   digitError    out  1   last conversion saw an unrecognised code
//   limitReached  out  1   last conversion met or passed the limit
//   busy          out  1   conversion in progress
// -----------------------------------------------------------------------------
module seven_seg_count_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample,
    input  logic [6:0] hexThreeCode,
    input  logic [6:0] hexFourCode,
    input  logic [6:0] hexFiveCode,
    input  logic [9:0] limit,
    output logic [9:0] count,
    output logic       countValid,
    output logic       digitError,
    output logic       limitReached,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACC_H = 3'd1,
        ACC_T = 3'd2,
        ACC_O = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [6:0] CODE_BLANK = 7'b1111111;

    // Returns {bad, digit}. Blank reads as 0 and is not an error.
    function automatic logic [4:0] seg_decode(input logic [6:0] code);
        case (code)
            7'b1000000: seg_decode = 5'b0_0000;
            7'b1111001: seg_decode = 5'b0_0001;
            7'b0100100: seg_decode = 5'b0_0010;
            7'b0110000: seg_decode = 5'b0_0011;
            7'b0011001: seg_decode = 5'b0_0100;
            7'b0010010: seg_decode = 5'b0_0101;
            7'b0000010: seg_decode = 5'b0_0110;
            7'b1111000: seg_decode = 5'b0_0111;
            7'b0000000: seg_decode = 5'b0_1000;
            7'b0010000: seg_decode = 5'b0_1001;
            7'b1111111: seg_decode = 5'b0_0000;
            default:    seg_decode = 5'b1_0000;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [6:0] code_q [3];          // 0 = ones, 1 = tens, 2 = hundreds
    logic [4:0] dec    [3];          // decoded {bad, digit} per latched code
    logic [9:0] acc_q, acc_d;
    logic       err_acc_q, err_acc_d;
    logic [9:0] count_q, count_d;
    logic       count_valid_q, count_valid_d;
    logic       digit_error_q, digit_error_d;
    logic       limit_reached_q, limit_reached_d;

    logic       capture;
    logic [9:0] acc_x10;
    logic [9:0] acc_plus_t;
    logic [9:0] result;

    // Decoders only ever see the latched copies, so input changes after the
    // capture edge cannot disturb a conversion in flight.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dec
            assign dec[gi] = seg_decode(code_q[gi]);
        end
    endgenerate

    assign capture    = (state_q == IDLE) && sample;
    assign acc_x10    = (acc_q << 3) + (acc_q << 1);
    assign acc_plus_t = acc_x10 + {6'd0, dec[1][3:0]};
    assign result     = acc_x10 + {6'd0, dec[0][3:0]};

    always_comb begin
        state_d         = state_q;
        acc_d           = acc_q;
        err_acc_d       = err_acc_q;
        count_d         = count_q;
        count_valid_d   = 1'b0;
        digit_error_d   = digit_error_q;
        limit_reached_d = limit_reached_q;
        case (state_q)
            IDLE: begin
                if (sample) begin
                    err_acc_d = 1'b0;
                    state_d   = ACC_H;
                end
            end
            ACC_H: begin
                acc_d     = {6'd0, dec[2][3:0]};
                err_acc_d = err_acc_q | dec[2][4];
                state_d   = ACC_T;
            end
            ACC_T: begin
                acc_d     = acc_plus_t;
                err_acc_d = err_acc_q | dec[1][4];
                state_d   = ACC_O;
            end
            ACC_O: begin
                count_d         = result;
                digit_error_d   = err_acc_q | dec[0][4];
                // limit is sampled here, not at capture.
                limit_reached_d = (limit != 10'd0) && (result >= limit);
                count_valid_d   = 1'b1;
                state_d         = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            acc_q           <= 10'd0;
            err_acc_q       <= 1'b0;
            count_q         <= 10'd0;
            count_valid_q   <= 1'b0;
            digit_error_q   <= 1'b0;
            limit_reached_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            acc_q           <= acc_d;
            err_acc_q       <= err_acc_d;
            count_q         <= count_d;
            count_valid_q   <= count_valid_d;
            digit_error_q   <= digit_error_d;
            limit_reached_q <= limit_reached_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                code_q[i] <= CODE_BLANK;
            end
        end else if (capture) begin
            code_q[0] <= hexThreeCode;
            code_q[1] <= hexFourCode;
            code_q[2] <= hexFiveCode;
        end
    end

    assign count        = count_q;
    assign countValid   = count_valid_q;
    assign digitError   = digit_error_q;
    assign limitReached = limit_reached_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_seven_seg_count_decoder.sv
// -----------------------------------------------------------------------------
// Directed testbench for seven_seg_count_decoder.
// -----------------------------------------------------------------------------
module tb_seven_seg_count_decoder;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SX = 7'b0101010;   // not a digit
    localparam logic [6:0] SY = 7'b1111110;   // not a digit

    logic       clk = 1'b0;
    logic       reset;
    logic       sample;
    logic [6:0] hexThreeCode;
    logic [6:0] hexFourCode;
    logic [6:0] hexFiveCode;
    logic [9:0] limit;
    logic [9:0] count;
    logic       countValid;
    logic       digitError;
    logic       limitReached;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    seven_seg_count_decoder dut (
        .clk          (clk),
        .reset        (reset),
        .sample       (sample),
        .hexThreeCode (hexThreeCode),
        .hexFourCode  (hexFourCode),
        .hexFiveCode  (hexFiveCode),
        .limit        (limit),
        .count        (count),
        .countValid   (countValid),
        .digitError   (digitError),
        .limitReached (limitReached),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full conversion: sample at edge k, checks through edge k+4.
    task automatic conv(input string tag, input logic [6:0] h, input logic [6:0] t,
                        input logic [6:0] o, input logic [9:0] lim,
                        input logic [9:0] exp_count, input logic exp_err,
                        input logic exp_lim);
        hexFiveCode  = h;
        hexFourCode  = t;
        hexThreeCode = o;
        limit        = lim;
        sample       = 1'b1;
        tick();                                   // edge k
        sample = 1'b0;
        check({tag, ".busy_k"}, busy, 1);
        tick();                                   // edge k+1
        tick();                                   // edge k+2
        check({tag, ".valid_k2"}, countValid, 0);
        tick();                                   // edge k+3
        check({tag, ".valid_k3"}, countValid, 1);
        check({tag, ".count"}, count, exp_count);
        check({tag, ".digitError"}, digitError, exp_err);
        check({tag, ".limitReached"}, limitReached, exp_lim);
        tick();                                   // edge k+4
        check({tag, ".valid_k4"}, countValid, 0);
        check({tag, ".busy_k4"}, busy, 0);
        $display("conv %s: count=%0d err=%0b lim=%0b", tag, count, digitError, limitReached);
    endtask

    initial begin
        reset        = 1'b1;
        sample       = 1'b0;
        hexThreeCode = SB;
        hexFourCode  = SB;
        hexFiveCode  = SB;
        limit        = 10'd0;
        tick();
        // Asynchronous reset mid-cycle
        #3 reset = 1'b0;
        #1;
        check("rst.count", count, 0);
        check("rst.countValid", countValid, 0);
        check("rst.digitError", digitError, 0);
        check("rst.limitReached", limitReached, 0);
        check("rst.busy", busy, 0);
        tick();
        reset = 1'b1;
        tick();
        $display("reset released");

        conv("blank", SB, SB, SB, 10'd0, 10'd0, 1'b0, 1'b0);
        conv("d127", S1, S2, S7, 10'd0, 10'd127, 1'b0, 1'b0);
        conv("bad509", S5, SX, S9, 10'd0, 10'd509, 1'b1, 1'b0);
        conv("d000", S0, S0, S0, 10'd0, 10'd0, 1'b0, 1'b0);
        conv("badH", SY, S4, S2, 10'd0, 10'd42, 1'b1, 1'b0);
        conv("blankmix", SB, S4, S2, 10'd0, 10'd42, 1'b0, 1'b0);
        conv("lim099", S0, S9, S9, 10'd100, 10'd99, 1'b0, 1'b0);
        conv("lim100", S1, S0, S0, 10'd100, 10'd100, 1'b0, 1'b1);
        conv("lim999", S9, S9, S9, 10'd100, 10'd999, 1'b0, 1'b1);
        conv("lim0_999", S9, S9, S9, 10'd0, 10'd999, 1'b0, 1'b0);

        // Busy / input hold: capture 3,4,5 then change inputs and poke sample.
        hexFiveCode  = S3;
        hexFourCode  = S4;
        hexThreeCode = S5;
        sample       = 1'b1;
        tick();                                   // k
        sample       = 1'b0;
        hexFiveCode  = S8;
        hexFourCode  = S8;
        hexThreeCode = S8;
        sample       = 1'b1;
        tick();                                   // k+1 (ignored)
        sample = 1'b0;
        tick();                                   // k+2
        tick();                                   // k+3
        check("hold.valid_k3", countValid, 1);
        check("hold.count345", count, 345);
        sample = 1'b1;
        tick();                                   // k+4 (ignored, DONE)
        check("hold.busy_k4", busy, 0);
        check("hold.valid_k4", countValid, 0);
        tick();                                   // k+5 accepted
        sample = 1'b0;
        check("hold.busy_k5", busy, 1);
        check("hold.count_held", count, 345);
        tick();                                   // k+6
        tick();                                   // k+7
        check("hold.valid_k7", countValid, 0);
        tick();                                   // k+8
        check("hold.valid_k8", countValid, 1);
        check("hold.count888", count, 888);
        tick();
        check("hold.busy_end", busy, 0);
        $display("hold sequence: count=%0d", count);

        // Reset mid-conversion
        hexFiveCode  = S1;
        hexFourCode  = S2;
        hexThreeCode = S3;
        sample       = 1'b1;
        tick();                                   // k
        sample = 1'b0;
        tick();                                   // k+1
        tick();                                   // k+2
        reset = 1'b0;
        #1;
        check("abort.busy", busy, 0);
        check("abort.count", count, 0);
        check("abort.countValid", countValid, 0);
        tick();
        tick();
        check("abort.valid_held", countValid, 0);
        check("abort.busy_held", busy, 0);
        reset = 1'b1;
        tick();
        $display("abort sequence done");
        conv("after_abort", S1, S2, S3, 10'd0, 10'd123, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
